// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding muxes and load-use hazard detection.
// Ports: ID_* decode inputs, MEM_*/WB_* forwarding sources, Stall/Flush
//   controls; EX_* drive the ALU and later stages, LoadUseStall holds upstream.
module id_ex_stage (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ID_Valid,
    input  logic [4:0]  ID_RegRs,
    input  logic [4:0]  ID_RegRt,
    input  logic [4:0]  ID_RegRd,
    input  logic [31:0] ID_ReadData1,
    input  logic [31:0] ID_ReadData2,
    input  logic [31:0] ID_SignExt,
    input  logic [4:0]  ID_Shamt,
    input  logic [3:0]  ID_ALUControl,
    input  logic        ID_ALUSrc,
    input  logic        ID_ShiftOp,
    input  logic        ID_RegDst,
    input  logic        ID_RegWrite,
    input  logic        ID_MemRead,
    input  logic        ID_MemWrite,
    input  logic        ID_MemToReg,
    input  logic        MEM_RegWrite,
    input  logic [4:0]  MEM_WriteReg,
    input  logic [31:0] MEM_ALUResult,
    input  logic        WB_RegWrite,
    input  logic [4:0]  WB_WriteReg,
    input  logic [31:0] WB_WriteData,
    input  logic        Stall,
    input  logic        Flush,
    output logic        LoadUseStall,
    output logic [31:0] EX_A,
    output logic [31:0] EX_B,
    output logic [3:0]  EX_ALUControl,
    output logic [31:0] EX_StoreData,
    output logic [4:0]  EX_WriteReg,
    output logic        EX_RegWrite,
    output logic        EX_MemRead,
    output logic        EX_MemWrite,
    output logic        EX_MemToReg,
    output logic        EX_Valid
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [4:0]  shamt;
        logic [3:0]  aluc;
        logic        alusrc;
        logic        shiftop;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        memtoreg;
    } id_ex_t;

    id_ex_t q;
    id_ex_t d;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    always_comb begin
        d          = '0;
        d.valid    = ID_Valid;
        d.rs       = ID_RegRs;
        d.rt       = ID_RegRt;
        d.wreg     = ID_RegDst ? ID_RegRd : ID_RegRt;
        d.rd1      = ID_ReadData1;
        d.rd2      = ID_ReadData2;
        d.sext     = ID_SignExt;
        d.shamt    = ID_Shamt;
        d.aluc     = ID_ALUControl;
        d.alusrc   = ID_ALUSrc;
        d.shiftop  = ID_ShiftOp;
        d.regwrite = ID_RegWrite;
        d.memread  = ID_MemRead;
        d.memwrite = ID_MemWrite;
        d.memtoreg = ID_MemToReg;
    end

    // A load in EX whose result the decode slot needs one cycle too early.
    assign LoadUseStall = q.valid & q.memread & (q.wreg != 5'd0) & ID_Valid &
                          ((q.wreg == ID_RegRs) | (q.wreg == ID_RegRt));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            q <= '0;
        else if (Flush)
            q <= '0;
        else if (Stall)
            q <= q;
        else if (LoadUseStall)
            q <= '0;
        else
            q <= d;
    end

    // Younger producer (MEM) wins over WB; $0 is hardwired and never forwarded.
    always_comb begin
        fwd_rs = q.rd1;
        if (MEM_RegWrite && MEM_WriteReg != 5'd0 && MEM_WriteReg == q.rs)
            fwd_rs = MEM_ALUResult;
        else if (WB_RegWrite && WB_WriteReg != 5'd0 && WB_WriteReg == q.rs)
            fwd_rs = WB_WriteData;
    end

    always_comb begin
        fwd_rt = q.rd2;
        if (MEM_RegWrite && MEM_WriteReg != 5'd0 && MEM_WriteReg == q.rt)
            fwd_rt = MEM_ALUResult;
        else if (WB_RegWrite && WB_WriteReg != 5'd0 && WB_WriteReg == q.rt)
            fwd_rt = WB_WriteData;
    end

    // Shifts operate on rt by the immediate shift amount.
    always_comb begin
        EX_A = fwd_rs;
        EX_B = fwd_rt;
        if (q.shiftop) begin
            EX_A = fwd_rt;
            EX_B = {27'b0, q.shamt};
        end else if (q.alusrc) begin
            EX_B = q.sext;
        end
    end

    assign EX_StoreData  = fwd_rt;
    assign EX_ALUControl = q.aluc;
    assign EX_WriteReg   = q.wreg;
    assign EX_RegWrite   = q.regwrite;
    assign EX_MemRead    = q.memread;
    assign EX_MemWrite   = q.memwrite;
    assign EX_MemToReg   = q.memtoreg;
    assign EX_Valid      = q.valid;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Registered decode-to-execute boundary of the pipelined MIPS datapath: captures decoded operands and control, resolves EX/MEM and MEM/WB forwarding, and drives the ALU's `A`, `B` and `ALUControl` inputs directly. It also detects load-use hazards and inserts bubbles, and honours external stall and flush requests from the hazard/branch logic.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register specifiers, 4-bit ALU control.
- `Clk` in 1: single clock, rising edge.
- `Reset` in 1: asynchronous, active-low.
- `ID_Valid` in 1: decode slot holds a real instruction.
- `ID_RegRs`, `ID_RegRt`, `ID_RegRd` in 5 each: decoded specifiers.
- `ID_ReadData1`, `ID_ReadData2` in 32 each: register-file reads for rs and rt.
- `ID_SignExt` in 32: sign-extended immediate.
- `ID_Shamt` in 5: shift amount.
- `ID_ALUControl` in 4: ALU opcode (0 add … 9 slt).
- `ID_ALUSrc`, `ID_ShiftOp`, `ID_RegDst`, `ID_RegWrite`, `ID_MemRead`, `ID_MemWrite`, `ID_MemToReg` in 1 each: control.
- `MEM_RegWrite` in 1, `MEM_WriteReg` in 5, `MEM_ALUResult` in 32: EX/MEM forwarding source.
- `WB_RegWrite` in 1, `WB_WriteReg` in 5, `WB_WriteData` in 32: MEM/WB forwarding source.
- `Stall` in 1: hold stage contents.
- `Flush` in 1: squash the incoming instruction.
- `LoadUseStall` out 1: combinational; upstream PC and IF/ID must hold.
- `EX_A`, `EX_B` out 32 each: ALU operands.
- `EX_ALUControl` out 4.
- `EX_StoreData` out 32: forwarded rt value for `sw`.
- `EX_WriteReg` out 5: destination, rd if RegDst else rt.
- `EX_RegWrite`, `EX_MemRead`, `EX_MemWrite`, `EX_MemToReg`, `EX_Valid` out 1 each.

## Operation
- **Registered fields:** Valid, rs, rt, WriteReg, ReadData1, ReadData2, SignExt, Shamt, ALUControl, ALUSrc, ShiftOp, RegWrite, MemRead, MemWrite, MemToReg.
- **Bubble:** all registered fields are 0. A bubble writes nothing and accesses no memory.
- **Load-use detection:** `LoadUseStall` = `EX_Valid & EX_MemRead & EX_WriteReg != 0 & ID_Valid & (EX_WriteReg == ID_RegRs | EX_WriteReg == ID_RegRt)`.
- **Update priority at each rising edge:**
  1. `Flush` → bubble.
  2. `Stall` → hold all fields.
  3. `LoadUseStall` → bubble.
  4. Otherwise → load from ID.
- **Forwarding:** applied to the registered rs and rt, producing `fwdRs` and `fwdRt`.
  - Source 1, MEM: `MEM_RegWrite & MEM_WriteReg != 0 & MEM_WriteReg == reg` → `MEM_ALUResult`.
  - Source 2, WB: `WB_RegWrite & WB_WriteReg != 0 & WB_WriteReg == reg` → `WB_WriteData`.
  - Else the registered ReadData.
  - MEM has priority over WB. Register 0 is never forwarded.
- **Operand select:**
  - ShiftOp: `EX_A` = `fwdRt`, `EX_B` = `{27'b0, Shamt}`.
  - Else: `EX_A` = `fwdRs`; `EX_B` = `SignExt` if ALUSrc, else `fwdRt`.
- `EX_StoreData` = `fwdRt` always.
- All other EX outputs mirror the registered fields directly.

## Timing
- **Reset:** while `Reset` = 0, all registers are cleared asynchronously. Every output reads 0: `EX_A`/`EX_B` 0, `EX_ALUControl` 0, all flags 0, `LoadUseStall` 0.
- **Latency:**
  - Decode inputs reach EX outputs 1 cycle after the capturing edge.
  - Forwarding and operand muxing are combinational within the same cycle.
- **LoadUseStall:** combinational from the current EX registers and ID inputs. It inserts exactly one bubble per load-use pair. On the next cycle the load has left EX, the signal deasserts, and the held instruction loads.
- **Simultaneous events:**
  - `Flush` with `Stall`: bubble.
  - `Flush` with `LoadUseStall`: bubble, and `LoadUseStall` is still driven high.
  - `Stall` with `LoadUseStall`: hold; no bubble is inserted.
- **Reset mid-operation:** the in-flight instruction is discarded immediately. The first edge after release loads normally.
- **Single-register case:** rs == rt with both matching a forwarding source forwards the same value on both paths.

## Test plan
- **Reset:** drive `Reset`=0 with nonzero ID inputs → all outputs 0. Release and load add with rs=$1 (5), rt=$2 (7), no forwarding → next cycle `EX_A`=5, `EX_B`=7, `EX_ALUControl`=0, `EX_Valid`=1.
- **MEM priority:** EX holds rs=$3. Set `MEM_RegWrite`=1, `MEM_WriteReg`=3, `MEM_ALUResult`=0x100; also `WB_WriteReg`=3 with `WB_WriteData`=0x200 → `EX_A`=0x100. Drop MEM → `EX_A`=0x200.
- **Register 0:** EX holds rs=$0, ReadData1=0. `MEM_WriteReg`=0, `MEM_RegWrite`=1, `MEM_ALUResult`=0xDEAD → `EX_A`=0.
- **Load-use:** EX holds lw with dest $4; ID presents add with rs=$4 → `LoadUseStall`=1, next edge produces a bubble (`EX_Valid`=0). Following cycle: `LoadUseStall`=0 and the add loads.
- **Shift and immediate:** sll with rt=$5 (0x1), Shamt=4 → `EX_A`=1, `EX_B`=4. addi with `ID_SignExt`=0xFFFFFFFF, ALUSrc=1 → `EX_B`=0xFFFFFFFF.
- **Stall/Flush interplay:**
  - `Stall`=1 for 3 cycles → outputs are unchanged.
  - `Stall`=1 with `Flush`=1 → bubble.
  - Async `Reset` pulse mid-cycle → outputs are 0 before the next edge.
